// File: rtl/dlx_ex_stage.sv
// dlx_ex_stage -- execute stage of the 5-stage DLX pipeline.
//
// Purpose:
//   A combinational 32-bit ALU produces the result and the condition flags
//   from the already-forwarded operands A and B. This block also owns the
//   EX/MEM interstage register. That register captures the ALU result, the
//   store data, the destination register number and the MEM/WB control bits
//   for the memory stage. Like the rest of the pipeline, it updates on the
//   falling edge of clk.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset (falling edge)
//   A, B              ALU operands (forwarded rs1 / rs2-or-immediate)
//   Op_ex             5-bit ALU operation code
//   MemtoReg_ex, RegWrite_ex, MemWrite_ex   control bits carried to MEM
//   towrite           destination register number
//   mem_data          store data (forwarded rs2)
//   Result_ex, Carryout, Overflow, Zero, Set   combinational ALU outputs
//   Result_mem, MemtoReg_mem, RegWrite_mem, MemWrite_mem,
//   towrite_ex, mem_data_ex                    registered EX/MEM outputs
module dlx_ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op_ex,
    input  logic             MemtoReg_ex,
    input  logic             RegWrite_ex,
    input  logic             MemWrite_ex,
    input  logic [4:0]       towrite,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] Result_ex,
    output logic             Carryout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Set,
    output logic [WIDTH-1:0] Result_mem,
    output logic             MemtoReg_mem,
    output logic             RegWrite_mem,
    output logic             MemWrite_mem,
    output logic [4:0]       towrite_ex,
    output logic [WIDTH-1:0] mem_data_ex
);

    localparam int SHW = $clog2(WIDTH);
    localparam int HW  = WIDTH / 2;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_SLL   = 5'd7;
    localparam logic [4:0] OP_SRL   = 5'd8;
    localparam logic [4:0] OP_SRA   = 5'd9;
    localparam logic [4:0] OP_SEQ   = 5'd10;
    localparam logic [4:0] OP_SNE   = 5'd11;
    localparam logic [4:0] OP_SLT   = 5'd12;
    localparam logic [4:0] OP_SGT   = 5'd13;
    localparam logic [4:0] OP_SLE   = 5'd14;
    localparam logic [4:0] OP_SGE   = 5'd15;
    localparam logic [4:0] OP_LHI   = 5'd16;
    localparam logic [4:0] OP_PASSA = 5'd17;
    localparam logic [4:0] OP_PASSB = 5'd18;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [SHW-1:0]   shamt;
    logic             lt_s;
    logic             eq;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             set_bit;

    // The unsigned sum and difference are computed one bit wider. Bit WIDTH
    // of the difference is the borrow, and the borrow is set exactly when
    // A < B unsigned.
    assign sum_w  = {1'b0, A} + {1'b0, B};
    assign diff_w = {1'b0, A} - {1'b0, B};
    assign shamt  = B[SHW-1:0];
    assign lt_s   = $signed(A) < $signed(B);
    assign eq     = (A == B);

    always_comb begin
        result  = '0;
        cout    = 1'b0;
        ovf     = 1'b0;
        set_bit = 1'b0;
        case (Op_ex)
            OP_ADD: begin
                result = sum_w[WIDTH-1:0];
                cout   = sum_w[WIDTH];
                ovf    = (A[WIDTH-1] == B[WIDTH-1]) &&
                         (sum_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADDU: begin
                result = sum_w[WIDTH-1:0];
                cout   = sum_w[WIDTH];
            end
            OP_SUB: begin
                result = diff_w[WIDTH-1:0];
                cout   = diff_w[WIDTH];
                ovf    = (A[WIDTH-1] != B[WIDTH-1]) &&
                         (diff_w[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUBU: begin
                result = diff_w[WIDTH-1:0];
                cout   = diff_w[WIDTH];
            end
            OP_AND:   result = A & B;
            OP_OR:    result = A | B;
            OP_XOR:   result = A ^ B;
            OP_SLL:   result = A << shamt;
            OP_SRL:   result = A >> shamt;
            OP_SRA:   result = $unsigned($signed(A) >>> shamt);
            OP_SEQ:   set_bit = eq;
            OP_SNE:   set_bit = !eq;
            OP_SLT:   set_bit = lt_s;
            OP_SGT:   set_bit = !lt_s && !eq;
            OP_SLE:   set_bit = lt_s || eq;
            OP_SGE:   set_bit = !lt_s;
            OP_LHI:   result = {B[HW-1:0], {HW{1'b0}}};
            OP_PASSA: result = A;
            OP_PASSB: result = B;
            default:  result = '0;
        endcase
        // Compare ops return the outcome in bit 0. Every other op leaves
        // set_bit at 0, so ORing it in is harmless.
        result[0] = result[0] | set_bit;
    end

    assign Result_ex = result;
    assign Carryout  = cout;
    assign Overflow  = ovf;
    assign Set       = set_bit;
    // Zero reflects the result for every code, including the unused ones.
    assign Zero      = (result == '0);

    // ------------------------------------------------------------------
    // EX/MEM register (falling edge). Reset turns the MEM stage into a bubble.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] result_mem_d,   result_mem_q;
    logic [WIDTH-1:0] mem_data_ex_d,  mem_data_ex_q;
    logic [4:0]       towrite_ex_d,   towrite_ex_q;
    logic             memtoreg_mem_d, memtoreg_mem_q;
    logic             regwrite_mem_d, regwrite_mem_q;
    logic             memwrite_mem_d, memwrite_mem_q;

    always_comb begin
        result_mem_d   = result;
        mem_data_ex_d  = mem_data;
        towrite_ex_d   = towrite;
        memtoreg_mem_d = MemtoReg_ex;
        regwrite_mem_d = RegWrite_ex;
        memwrite_mem_d = MemWrite_ex;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            result_mem_q   <= '0;
            mem_data_ex_q  <= '0;
            towrite_ex_q   <= '0;
            memtoreg_mem_q <= 1'b0;
            regwrite_mem_q <= 1'b0;
            memwrite_mem_q <= 1'b0;
        end else begin
            result_mem_q   <= result_mem_d;
            mem_data_ex_q  <= mem_data_ex_d;
            towrite_ex_q   <= towrite_ex_d;
            memtoreg_mem_q <= memtoreg_mem_d;
            regwrite_mem_q <= regwrite_mem_d;
            memwrite_mem_q <= memwrite_mem_d;
        end
    end

    assign Result_mem   = result_mem_q;
    assign mem_data_ex  = mem_data_ex_q;
    assign towrite_ex   = towrite_ex_q;
    assign MemtoReg_mem = memtoreg_mem_q;
    assign RegWrite_mem = regwrite_mem_q;
    assign MemWrite_mem = memwrite_mem_q;

endmodule

// File: tb/tb_dlx_ex_stage.sv
module tb_dlx_ex_stage;

    localparam int W = 72;   // {result, mem_data, towrite, memtoreg, regwrite, memwrite}
    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;
    localparam longint TWO32 = 64'sd4294967296;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        set;
    } alu_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b1;
    logic        reset;
    logic [31:0] A, B, mem_data;
    logic [4:0]  Op_ex, towrite;
    logic        MemtoReg_ex, RegWrite_ex, MemWrite_ex;
    logic [31:0] Result_ex, Result_mem, mem_data_ex;
    logic        Carryout, Overflow, Zero, Set;
    logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem;
    logic [4:0]  towrite_ex;

    always #5 clk = ~clk;

    dlx_ex_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op_ex(Op_ex),
        .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
        .MemWrite_ex(MemWrite_ex), .towrite(towrite), .mem_data(mem_data),
        .Result_ex(Result_ex), .Carryout(Carryout), .Overflow(Overflow),
        .Zero(Zero), .Set(Set), .Result_mem(Result_mem),
        .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem),
        .MemWrite_mem(MemWrite_mem), .towrite_ex(towrite_ex),
        .mem_data_ex(mem_data_ex)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference ALU written with wide signed/unsigned integer arithmetic.
    function automatic alu_t model(input int op, input logic [31:0] a, input logic [31:0] b);
        alu_t   m;
        longint ua, ub, sa, sb, r, t;
        int     sh;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        r  = 0;
        m  = '0;
        case (op)
            0, 1: begin
                r = ua + ub;
                m.cout = (r >= TWO32);
                t = sa + sb;
                if (op == 0) m.ovf = (t > MAXS) || (t < MINS);
            end
            2, 3: begin
                r = ua - ub;
                m.cout = (ua < ub);
                t = sa - sb;
                if (op == 2) m.ovf = (t > MAXS) || (t < MINS);
            end
            4: r = ua & ub;
            5: r = ua | ub;
            6: r = ua ^ ub;
            7: r = ua * (64'sd1 <<< sh);
            8: r = ua / (64'sd1 <<< sh);
            9: r = sa >>> sh;
            10: r = (sa == sb) ? 1 : 0;
            11: r = (sa != sb) ? 1 : 0;
            12: r = (sa <  sb) ? 1 : 0;
            13: r = (sa >  sb) ? 1 : 0;
            14: r = (sa <= sb) ? 1 : 0;
            15: r = (sa >= sb) ? 1 : 0;
            16: r = (ub % 65536) * 65536;
            17: r = ua;
            18: r = ub;
            default: r = 0;
        endcase
        m.res  = r[31:0];
        m.zero = (m.res == 32'd0);
        m.set  = (op >= 10 && op <= 15) && (r == 1);
        return m;
    endfunction

    // ---------------- driver ----------------
    // Drive one instruction, check the ALU, then check the EX/MEM register
    // one falling edge later.
    task automatic run_cycle(input int op, input logic [31:0] a, input logic [31:0] b,
                             input logic mtr, input logic rw, input logic mw,
                             input logic [4:0] tw, input logic [31:0] md, input logic rst);
        alu_t         m;
        logic [W-1:0] e;
        string        s;
        reset = rst; Op_ex = 5'(op); A = a; B = b;
        MemtoReg_ex = mtr; RegWrite_ex = rw; MemWrite_ex = mw;
        towrite = tw; mem_data = md;
        #1;
        m = model(op, a, b);
        s = $sformatf("op%0d a=%h b=%h", op, a, b);
        check({s, " result"}, Result_ex, m.res);
        check({s, " carry"}, {31'b0, Carryout}, {31'b0, m.cout});
        check({s, " ovf"}, {31'b0, Overflow}, {31'b0, m.ovf});
        check({s, " set"}, {31'b0, Set}, {31'b0, m.set});
        if (op <= 18) check({s, " zero"}, {31'b0, Zero}, {31'b0, m.zero});
        exp_q.push_back(rst ? '0 : {m.res, md, tw, mtr, rw, mw});
        @(negedge clk);
        #1;
        e = exp_q.pop_front();
        check({s, " result_mem"}, Result_mem, e[71:40]);
        check({s, " mem_data_ex"}, mem_data_ex, e[39:8]);
        check({s, " towrite_ex"}, {27'b0, towrite_ex}, {27'b0, e[7:3]});
        check({s, " ctrl_mem"}, {29'b0, MemtoReg_mem, RegWrite_mem, MemWrite_mem},
              {29'b0, e[2:0]});
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        // Reset with busy inputs: registers must still clear.
        run_cycle(1, 32'h11, 32'h22, 1, 1, 1, 5'd31, 32'hCAFEF00D, 1'b1);

        // Directed cases
        run_cycle(0,  32'h7FFFFFFF, 32'h1, 0, 1, 0, 5'd3, 32'h0, 1'b0);
        run_cycle(1,  32'hFFFFFFFF, 32'h1, 0, 1, 0, 5'd4, 32'h0, 1'b0);
        run_cycle(2,  32'd5, 32'd7, 0, 1, 0, 5'd5, 32'h0, 1'b0);
        run_cycle(12, 32'd5, 32'd7, 0, 1, 0, 5'd6, 32'h0, 1'b0);
        run_cycle(15, 32'd5, 32'd7, 0, 1, 0, 5'd7, 32'h0, 1'b0);
        run_cycle(9,  32'h80000000, 32'h24, 0, 1, 0, 5'd8, 32'h0, 1'b0);
        run_cycle(8,  32'h80000000, 32'h24, 0, 1, 0, 5'd8, 32'h0, 1'b0);
        run_cycle(16, 32'h0, 32'h1234, 0, 1, 0, 5'd8, 32'h0, 1'b0);
        run_cycle(0,  32'h100, 32'h4, 0, 0, 1, 5'd9, 32'hDEADBEEF, 1'b0);
        run_cycle(2,  32'h80000000, 32'h1, 0, 1, 0, 5'd10, 32'h0, 1'b0);
        run_cycle(25, 32'h1234, 32'h5678, 0, 1, 0, 5'd11, 32'h0, 1'b0);
        // Nonzero load, then reset mid-stream drops it
        run_cycle(17, 32'hA5A5A5A5, 32'h0, 1, 1, 1, 5'd12, 32'h12345678, 1'b0);
        run_cycle(5,  32'hF0F0F0F0, 32'h0F0F0F0F, 1, 1, 1, 5'd13, 32'h87654321, 1'b1);

        // Randomized
        for (int i = 0; i < 400; i++) begin
            run_cycle(int'($urandom_range(0, 31)), rand_operand(), rand_operand(),
                      1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                      ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
